// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline constants and types for the stall/flush controller.
// State encoding, drain length and register-ID width live here.
package pipe_stall_ctrl_pkg;

    localparam int REG_ID_W  = 3;
    localparam int DRAIN_CYC = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall controller.
// The datapath side is the master, the controller is the slave.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_stall_ctrl_pkg::*;

    logic [REG_ID_W-1:0] dec_ReadReg1;
    logic [REG_ID_W-1:0] dec_ReadReg2;
    logic                dec_Reg1Used;
    logic                dec_Reg2Used;
    logic                dec_Halt;
    logic [REG_ID_W-1:0] exe_WriteReg;
    logic                exe_RegWrite;
    logic                exe_DMemRead;
    logic                exe_BranchTaken;
    logic                imem_Busy;
    logic                dmem_Busy;

    logic                pc_En;
    logic                ifid_En;
    logic                idex_En;
    logic                exmem_En;
    logic                memwb_En;
    logic                ifid_Flush;
    logic                idex_Bubble;
    logic                halted;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output dec_ReadReg1, dec_ReadReg2,
        output dec_Reg1Used, dec_Reg2Used, dec_Halt,
        output exe_WriteReg, exe_RegWrite, exe_DMemRead,
        output exe_BranchTaken, imem_Busy, dmem_Busy,
        input  pc_En, ifid_En, idex_En, exmem_En, memwb_En,
        input  ifid_Flush, idex_Bubble, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_ReadReg1, dec_ReadReg2,
        input  dec_Reg1Used, dec_Reg2Used, dec_Halt,
        input  exe_WriteReg, exe_RegWrite, exe_DMemRead,
        input  exe_BranchTaken, imem_Busy, dmem_Busy,
        output pc_En, ifid_En, idex_En, exmem_En, memwb_En,
        output ifid_Flush, idex_Bubble, halted,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: step by one unless already pinned at the top
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // count register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: memory freezes, branch flushes,
// load-use bubbles, fetch stalls and halt draining.
module pipe_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = pipe_stall_ctrl_pkg::DRAIN_CYC
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);
    import pipe_stall_ctrl_pkg::*;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e          state_q;
    state_e          state_d;
    state_e          ret_q;
    state_e          ret_d;
    state_e          eff;
    logic [DW-1:0]   drain_q;
    logic [DW-1:0]   drain_d;

    logic            load_use;
    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            stall_inc;
    logic            flush_inc;

    // hazard: a load in EX writes a register decode is about to read
    always_comb begin
        load_use = bus.exe_RegWrite & bus.exe_DMemRead &
                   ((bus.dec_Reg1Used &
                     (bus.exe_WriteReg == bus.dec_ReadReg1)) |
                    (bus.dec_Reg2Used &
                     (bus.exe_WriteReg == bus.dec_ReadReg2)));
    end

    // next-state and control decode, highest-priority event first
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        drain_d     = drain_q;
        // a finished memory wait behaves as the state it interrupted
        eff = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (state_q == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (bus.dmem_Busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else if (bus.exe_BranchTaken) begin
            // redirect squashes fetch and decode; also cancels a halt
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
            ret_d       = RUN;
        end else if (eff == DRAIN) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (drain_q == '0) begin
                state_d = HALTED;
            end else begin
                drain_d = drain_q - DW'(1);
                state_d = DRAIN;
            end
        end else begin
            state_d = RUN;
            priority case (1'b1)
                load_use: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
                bus.imem_Busy: begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                bus.dec_Halt: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYC - 1);
                end
                default: begin
                end
            endcase
        end

        stall_inc = ~pc_en & (state_q != HALTED);
    end

    // controller state, saved return state and drain countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            drain_q <= drain_d;
        end
    end

    // outputs forced quiet while reset is asserted
    assign bus.pc_En       = pc_en & ~rst;
    assign bus.ifid_En     = ifid_en & ~rst;
    assign bus.idex_En     = idex_en & ~rst;
    assign bus.exmem_En    = exmem_en & ~rst;
    assign bus.memwb_En    = memwb_en & ~rst;
    assign bus.ifid_Flush  = ifid_flush & ~rst;
    assign bus.idex_Bubble = idex_bubble & ~rst;
    assign bus.halted      = (state_q == HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expected control vectors
// are queued as stimulus is driven and checked at the falling edge.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus ();

    pipe_stall_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] r1;
        logic [2:0] r2;
        logic       u1;
        logic       u2;
        logic       hlt;
        logic [2:0] wr;
        logic       rw;
        logic       dmr;
        logic       br;
        logic       ib;
        logic       db;
    } stim_t;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    // ctl = {pc,ifid,idex,exmem,memwb,flush,bubble,halted}
    localparam logic [7:0] ALL1  = 8'b11111_00_0;
    localparam logic [7:0] FROZ  = 8'b00000_00_0;
    localparam logic [7:0] BR    = 8'b11111_11_0;
    localparam logic [7:0] LU    = 8'b00111_01_0;
    localparam logic [7:0] IM    = 8'b01111_10_0;
    localparam logic [7:0] HLT   = 8'b00111_00_0;
    localparam logic [7:0] DRN   = 8'b00111_01_0;
    localparam logic [7:0] HALTD = 8'b00000_00_1;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] es = '0;
    logic [15:0] ef = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {bus.pc_En, bus.ifid_En, bus.idex_En, bus.exmem_En,
                bus.memwb_En, bus.ifid_Flush, bus.idex_Bubble,
                bus.halted};
    endfunction

    function automatic stim_t mk(
        logic [2:0] r1, logic [2:0] r2, logic u1, logic u2,
        logic hlt, logic [2:0] wr, logic rw, logic dmr,
        logic br, logic ib, logic db);
        stim_t s;
        s = '{r1, r2, u1, u2, hlt, wr, rw, dmr, br, ib, db};
        return s;
    endfunction

    task automatic drive(stim_t s);
        bus.dec_ReadReg1    = s.r1;
        bus.dec_ReadReg2    = s.r2;
        bus.dec_Reg1Used    = s.u1;
        bus.dec_Reg2Used    = s.u2;
        bus.dec_Halt        = s.hlt;
        bus.exe_WriteReg    = s.wr;
        bus.exe_RegWrite    = s.rw;
        bus.exe_DMemRead    = s.dmr;
        bus.exe_BranchTaken = s.br;
        bus.imem_Busy       = s.ib;
        bus.dmem_Busy       = s.db;
    endtask

    task automatic step(string tag, stim_t s, logic [7:0] ctl);
        exp_t e;
        drive(s);
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = es;
        e.flush = ef;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.tag, ".ctl"}, {24'd0, ctl_now()}, {24'd0, e.ctl});
        chk({e.tag, ".stall"}, {16'd0, bus.stall_cnt}, {16'd0, e.stall});
        chk({e.tag, ".flush"}, {16'd0, bus.flush_cnt}, {16'd0, e.flush});
        if (!ctl[7] && !ctl[0] && es != 16'hFFFF) es++;
        if (ctl[7] && ctl[2] && ctl[1]) ef++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        drive('0);
        #2;
        chk({tag, ".rst_ctl"}, {24'd0, ctl_now()}, {24'd0, FROZ});
        chk({tag, ".rst_stall"}, {16'd0, bus.stall_cnt}, 32'd0);
        chk({tag, ".rst_flush"}, {16'd0, bus.flush_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        es  = '0;
        ef  = '0;
    endtask

    stim_t IDLE, LD_R1, LD_R1_NU, LD_R2, LD_NOWR, LD_NOLD;
    stim_t BR_LU, IMEM, HALT, DM_BR, DMEM, BRANCH;

    initial begin
        IDLE     = '0;
        LD_R1    = mk(3'd2, 3'd5, 1, 0, 0, 3'd2, 1, 1, 0, 0, 0);
        LD_R1_NU = mk(3'd2, 3'd5, 0, 0, 0, 3'd2, 1, 1, 0, 0, 0);
        LD_R2    = mk(3'd4, 3'd2, 1, 1, 0, 3'd2, 1, 1, 0, 0, 0);
        LD_NOWR  = mk(3'd2, 3'd5, 1, 0, 0, 3'd2, 0, 1, 0, 0, 0);
        LD_NOLD  = mk(3'd2, 3'd5, 1, 0, 0, 3'd2, 1, 0, 0, 0, 0);
        BR_LU    = mk(3'd2, 3'd5, 1, 0, 0, 3'd2, 1, 1, 1, 0, 0);
        IMEM     = mk(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0);
        HALT     = mk(3'd0, 3'd0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0);
        DM_BR    = mk(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 1);
        DMEM     = mk(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        BRANCH   = mk(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);

        drive('0);
        @(posedge clk);
        #1;
        do_reset("r0");
        step("idle", IDLE, ALL1);

        // load-use on either source, and near-misses
        step("lu_r1", LD_R1, LU);
        step("lu_after", IDLE, ALL1);
        step("lu_unused", LD_R1_NU, ALL1);
        step("lu_r2", LD_R2, LU);
        step("lu_nowr", LD_NOWR, ALL1);
        step("lu_nold", LD_NOLD, ALL1);

        // branch beats load-use; fetch stall
        step("br_lu", BR_LU, BR);
        step("imem", IMEM, IM);
        step("idle2", IDLE, ALL1);

        // memory freeze with a pending branch
        do_reset("r1");
        for (int i = 0; i < 4; i++) step("dm_br", DM_BR, FROZ);
        step("dm_done_br", BRANCH, BR);
        step("dm_after", IDLE, ALL1);

        // load-use re-evaluated on the cycle memory completes
        step("dm1", DMEM, FROZ);
        step("dm_lu", LD_R1, LU);
        step("dm_lu_after", IDLE, ALL1);

        // halt cancelled by a younger branch
        do_reset("r2");
        step("h_cancel", HALT, HLT);
        step("h_cancel_br", BRANCH, BR);
        step("h_cancel_run", IDLE, ALL1);
        step("h_cancel_run2", IDLE, ALL1);

        // halt with a memory freeze inside the drain
        step("h", HALT, HLT);
        step("d1", IDLE, DRN);
        step("d_frz", DMEM, FROZ);
        step("d2", IDLE, DRN);
        step("d3", IDLE, DRN);
        step("halted", IDLE, HALTD);
        step("halted_br", BRANCH, HALTD);
        step("halted_dm", DMEM, HALTD);
        step("halted_ld", LD_R1, HALTD);

        // reset in the middle of a memory wait
        do_reset("r3");
        step("mw1", DMEM, FROZ);
        step("mw2", DMEM, FROZ);
        do_reset("r_mw");
        step("mw_post", IDLE, ALL1);

        // reset in the middle of a drain
        step("md_h", HALT, HLT);
        step("md_d1", IDLE, DRN);
        do_reset("r_md");
        step("md_post", IDLE, ALL1);

        // stall counter saturation
        do_reset("r4");
        drive(IMEM);
        repeat (16'hFFFE) @(posedge clk);
        #1;
        es = 16'hFFFE;
        step("sat0", IMEM, IM);
        step("sat1", IMEM, IM);
        step("sat2", IMEM, IM);
        step("sat_hold", IDLE, ALL1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: still running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush statistics counters.
REQ-002 SHALL have parameter DRAIN_CYC, default 3, cycles for a halt in decode to retire through WB.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 dec_ReadReg1, dec_ReadReg2  in  3  decode source register IDs.
REQ-006 dec_Reg1Used, dec_Reg2Used  in  1  decode source actually read.
REQ-007 dec_Halt  in  1  halt instruction in decode.
REQ-008 exe_WriteReg  in  3; exe_RegWrite, exe_DMemRead  in  1  EX destination, write-enable, load flag.
REQ-009 exe_BranchTaken  in  1  branch/jump redirect resolved in EX.
REQ-010 imem_Busy, dmem_Busy  in  1  instruction/data memory not done this cycle.
REQ-011 pc_En, ifid_En, idex_En, exmem_En, memwb_En  out  1  pipeline register write enables.
REQ-012 ifid_Flush, idex_Bubble  out  1  insert NOP into IF/ID, ID/EX.
REQ-013 halted  out  1  processor stopped.
REQ-014 stall_cnt, flush_cnt  out  CNT_W  statistics.

Function
REQ-015 FSM states SHALL be RUN, MEM_WAIT, DRAIN, HALTED; outputs combinational from state and inputs.
REQ-016 load_use SHALL be exe_RegWrite & exe_DMemRead & ((dec_Reg1Used & exe_WriteReg==dec_ReadReg1) | (dec_Reg2Used & exe_WriteReg==dec_ReadReg2)).
REQ-017 In RUN, priority SHALL be dmem_Busy > exe_BranchTaken > load_use > imem_Busy > dec_Halt.
REQ-018 dmem_Busy in RUN or DRAIN: all five enables 0, no flush/bubble; next state MEM_WAIT; return state (RUN or DRAIN) saved.
REQ-019 MEM_WAIT: enables held 0 while dmem_Busy; first cycle dmem_Busy=0, all enables 1 and return to saved state; branch/load_use/halt re-evaluated that cycle per REQ-017.
REQ-020 exe_BranchTaken (not frozen): pc_En=1, ifid_Flush=1, idex_Bubble=1, other enables 1; flush_cnt +1.
REQ-021 load_use (no branch): pc_En=0, ifid_En=0, idex_Bubble=1, exmem_En=memwb_En=1; exactly one bubble per load-use pair.
REQ-022 imem_Busy (no higher event): pc_En=0, ifid_Flush=1, downstream enables 1.
REQ-023 dec_Halt (no higher event): pc_En=0, ifid_En=0, downstream enables 1; enter DRAIN, drain counter loaded DRAIN_CYC-1.
REQ-024 DRAIN: pc_En=ifid_En=0, idex_Bubble=1, downstream 1; counter -1 per unfrozen cycle; at 0 go HALTED.
REQ-025 exe_BranchTaken in DRAIN SHALL cancel the halt (younger): branch response per REQ-020, return to RUN.
REQ-026 HALTED: all enables 0, halted=1, sticky until rst.
REQ-027 stall_cnt SHALL +1 each cycle pc_En=0 in RUN/MEM_WAIT/DRAIN; both counters saturate at all-ones, no wrap.
REQ-028 Signals with no event: all enables 1, flush/bubble 0.

Reset
REQ-029 rst SHALL asynchronously force state RUN, drain counter 0, saved state RUN, stall_cnt=flush_cnt=0, halted=0.
REQ-030 While rst is high all enables SHALL be 0; rst mid-MEM_WAIT or mid-DRAIN discards the pending operation.

Structure
REQ-031 State encodings, DRAIN_CYC and REG_ID_W=3 SHALL live in the shared pipeline package.
REQ-032 One sub-module, sat_counter (CNT_W, inc, saturating), SHALL be instantiated twice.

Verification
REQ-033 Load r2 in EX, dec reads r2 used -> one cycle pc_En=0, idex_Bubble=1; next cycle all enables 1; stall_cnt=1.
REQ-034 dmem_Busy high 4 cycles with exe_BranchTaken=1 -> enables 0 for 4 cycles, then flush cycle; flush_cnt=1, stall_cnt=4.
REQ-035 Branch and load_use same cycle -> ifid_Flush=1, idex_Bubble=1, pc_En=1; stall_cnt unchanged.
REQ-036 dec_Halt, no events -> DRAIN 3 cycles then halted=1 forever; branch in first DRAIN cycle -> RUN, halted stays 0.
REQ-037 Force stall_cnt to 0xFFFE, 3 stall cycles -> reads 0xFFFF, no wrap.
REQ-038 rst pulsed mid-MEM_WAIT -> counters 0, state RUN, enables 1 the cycle after release.
